// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - shared types and helpers for the dot-product engine
// Purpose: FSM state encoding and the accumulator-width helper used to size
//          the internal sum so it can never overflow.
// Ports:   none (package).
package dot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    ACC,
    DONE
  } state_t;

  // Worst-case |a*b| needs 2*dw bits; summing len of them adds clog2(len).
  function automatic int acc_width(input int len, input int dw);
    return 2 * dw + $clog2(len);
  endfunction

endpackage

// File: rtl/dot_product_engine_if.sv
// rtl/dot_product_engine_if.sv - request/result bundle of the dot-product engine
// Purpose: groups the start/busy/done handshake, operand vectors and result.
// Ports:   master drives start, signed_mode, a_vec, b_vec and observes
//          busy, done, result, sat; slave is the engine side.
interface dot_product_engine_if #(
  parameter int LEN  = 16,
  parameter int DW   = 8,
  parameter int OUTW = 16
);

  logic                start;
  logic                signed_mode;
  logic [LEN*DW-1:0]   a_vec;
  logic [LEN*DW-1:0]   b_vec;
  logic                busy;
  logic                done;
  logic [OUTW-1:0]     result;
  logic                sat;

  modport master (
    output start, signed_mode, a_vec, b_vec,
    input  busy, done, result, sat
  );

  modport slave (
    input  start, signed_mode, a_vec, b_vec,
    output busy, done, result, sat
  );

endinterface

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - DW-bit unsigned radix-2 shift-add multiplier
// Purpose: multiplies two unsigned operands one multiplier bit per cycle,
//          DW cycles after load, no DSP primitives.
// Ports:   clk, rst_n (sync, active-low); load captures a/b and clears the
//          product; done is high during the final iteration cycle, so prod
//          is complete right after that edge; prod is the 2*DW-bit result.
module shift_add_mul #(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     b,
  output logic [2*DW-1:0]   prod,
  output logic              done
);

  localparam int CW = $clog2(DW + 1);

  logic [2*DW-1:0] mcand;
  logic [2*DW-1:0] p_reg;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      p_reg  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{DW{1'b0}}, a};
      mplier <= b;
      p_reg  <= '0;
      cnt    <= CW'(DW);
    end else if (cnt != '0) begin
      if (mplier[0]) begin
        p_reg <= p_reg + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  // Announce the last step one cycle early so the caller can leave its
  // multiply state on the very edge that completes the product.
  assign done = (cnt == CW'(1));
  assign prod = p_reg;

endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - sequential DSP-free dot-product engine (top)
// Purpose: result = sum(a[i]*b[i]) over LEN elements, unsigned or signed,
//          one element per DW+1 cycles using shift_add_mul.
// Ports:   clk, rst_n (sync, active-low); bus (slave modport): start,
//          signed_mode, a_vec, b_vec in; busy, done, result, sat out.
// Config:  DOT_SAT_EN defined -> result clipped to the OUTW range, sat flags
//          clipping; undefined -> result wraps to OUTW bits, sat stays 0.
module dot_product_engine
  import dot_pkg::*;
#(
  parameter int LEN  = 16,
  parameter int DW   = 8,
  parameter int ACCW = acc_width(LEN, DW),
  parameter int OUTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dot_product_engine_if.slave  bus
);

  localparam int          IW   = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);

  state_t             state;
  logic [LEN*DW-1:0]  a_reg;
  logic [LEN*DW-1:0]  b_reg;
  logic               sm_reg;
  logic               neg;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      nidx;
  logic [ACCW-1:0]    acc;
  logic [ACCW-1:0]    term;
  logic [ACCW-1:0]    acc_next;

  logic [DW-1:0]      a_sel;
  logic [DW-1:0]      b_sel;
  logic               sm_sel;
  logic [DW-1:0]      a_mag;
  logic [DW-1:0]      b_mag;
  logic               neg_sel;
  logic               mul_load;
  logic               mul_done;
  logic [2*DW-1:0]    prod;

  logic [OUTW-1:0]    res_next;
  logic               sat_next;

  // Element 0 is fed straight from the bus during LOAD so its multiply can
  // start on the LOAD edge; later elements come from the latched copy and
  // are loaded on the ACC edge of the previous element.
  assign nidx = (idx == LAST) ? '0 : idx + 1'b1;

  always_comb begin
    if (state == LOAD) begin
      a_sel  = bus.a_vec[DW-1:0];
      b_sel  = bus.b_vec[DW-1:0];
      sm_sel = bus.signed_mode;
    end else begin
      a_sel  = a_reg[nidx*DW +: DW];
      b_sel  = b_reg[nidx*DW +: DW];
      sm_sel = sm_reg;
    end
  end

  // -2^(DW-1) negates to 2^(DW-1), which still fits DW unsigned bits.
  assign a_mag    = (sm_sel && a_sel[DW-1]) ? DW'(-a_sel) : a_sel;
  assign b_mag    = (sm_sel && b_sel[DW-1]) ? DW'(-b_sel) : b_sel;
  assign neg_sel  = sm_sel & (a_sel[DW-1] ^ b_sel[DW-1]);
  assign mul_load = (state == LOAD) || ((state == ACC) && (idx != LAST));

  shift_add_mul #(.DW(DW)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mul_load),
    .a     (a_mag),
    .b     (b_mag),
    .prod  (prod),
    .done  (mul_done)
  );

  assign term     = neg ? ACCW'(-ACCW'(prod)) : ACCW'(prod);
  assign acc_next = acc + term;

`ifdef DOT_SAT_EN
  localparam logic [ACCW-1:0] UMAX = ACCW'((ACCW'(1) << OUTW) - 1'b1);
  localparam logic [ACCW-1:0] SMAX = ACCW'((ACCW'(1) << (OUTW - 1)) - 1'b1);
  localparam logic [ACCW-1:0] SMIN = ~SMAX;
`endif

  always_comb begin
    res_next = acc_next[OUTW-1:0];
    sat_next = 1'b0;
`ifdef DOT_SAT_EN
    if (sm_reg) begin
      if ($signed(acc_next) > $signed(SMAX)) begin
        res_next = SMAX[OUTW-1:0];
        sat_next = 1'b1;
      end else if ($signed(acc_next) < $signed(SMIN)) begin
        res_next = SMIN[OUTW-1:0];
        sat_next = 1'b1;
      end
    end else if (acc_next > UMAX) begin
      res_next = UMAX[OUTW-1:0];
      sat_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.sat    <= 1'b0;
      acc        <= '0;
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      sm_reg     <= 1'b0;
      neg        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= LOAD;
            bus.busy <= 1'b1;
          end
        end
        LOAD: begin
          a_reg  <= bus.a_vec;
          b_reg  <= bus.b_vec;
          sm_reg <= bus.signed_mode;
          neg    <= neg_sel;
          acc    <= '0;
          idx    <= '0;
          state  <= MUL;
        end
        MUL: begin
          if (mul_done) begin
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          neg <= neg_sel;
          if (idx == LAST) begin
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.result <= res_next;
            bus.sat    <= sat_next;
          end else begin
            idx   <= idx + 1'b1;
            state <= MUL;
          end
        end
        DONE: begin
          // The DONE cycle is the idle slot between runs: a start held high
          // here chains straight into the next LOAD, keeping busy asserted.
          if (bus.start) begin
            state <= LOAD;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
